// File: rtl/fir_pkg.sv
// Shared defaults and the controller state encoding for the FIR driver.
package fir_pkg;

  localparam int unsigned NumTapsDefault  = 5;
  localparam int unsigned DataWDefault    = 8;
  localparam int unsigned OutWDefault     = 16;
  localparam int unsigned ResDepthDefault = 4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StGap    = 3'd2,
    StStream = 3'd3,
    StDrain  = 3'd4,
    StFault  = 3'd5
  } fir_state_e;

endpackage

// File: rtl/fir_res_fifo.sv
// Result FIFO: registered storage, head presented combinationally, occupancy count output.
module fir_res_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       head_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next-state: write at tail, advance pointers (Depth is a power of two, so they wrap freely).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fir_driver.sv
// Host-side driver for an external FIR filter: loads taps, streams samples under a
// credit limit so results always fit in the local FIFO, and latches filter faults.
module fir_driver
  import fir_pkg::*;
#(
  parameter int unsigned NUM_TAPS  = NumTapsDefault,
  parameter int unsigned DATA_W    = DataWDefault,
  parameter int unsigned OUT_W     = OutWDefault,
  parameter int unsigned RES_DEPTH = ResDepthDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] coef_data,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              smp_valid,
  output logic              smp_ready,
  output logic [DATA_W-1:0] fir_data_in,
  output logic              fir_coef_enable,
  output logic              fir_sample_enable,
  input  logic [OUT_W-1:0]  fir_data_out,
  input  logic              fir_out_enable,
  input  logic              fir_error,
  output logic [OUT_W-1:0]  res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CntW = $clog2(RES_DEPTH) + 1;
  localparam int unsigned TapW = $clog2(NUM_TAPS + 1);

  fir_state_e        state_q, state_d;
  logic [TapW-1:0]   tap_cnt_q, tap_cnt_d;
  logic [CntW-1:0]   out_cnt_q, out_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              coef_en_q, coef_en_d;
  logic              smp_en_q, smp_en_d;
  logic              err_q, err_d;

  logic [CntW-1:0]   fifo_count;
  logic              fifo_empty, fifo_full;
  logic [CntW:0]     credit_used;
  logic              fault_hit, ret_ok, coef_xfer, smp_xfer, fifo_push, fifo_pop;

  // Samples in flight plus results waiting can never exceed the FIFO depth.
  assign credit_used = {1'b0, out_cnt_q} + {1'b0, fifo_count};
  // A return with nothing outstanding means the filter and driver are out of step.
  assign fault_hit   = fir_error || (fir_out_enable && (out_cnt_q == '0));
  assign ret_ok      = fir_out_enable && !fault_hit && (state_q != StFault);

  // Readiness is withheld on a faulting cycle so no enable follows the fault.
  assign coef_ready = (state_q == StLoad) && !fault_hit;
  assign smp_ready  = (state_q == StStream) && !stop && !fault_hit &&
                      (credit_used < (CntW + 1)'(RES_DEPTH));
  assign coef_xfer  = coef_valid && coef_ready;
  assign smp_xfer   = smp_valid && smp_ready;
  assign fifo_push  = ret_ok && !fifo_full;
  assign fifo_pop   = res_valid && res_ready;

  assign fir_data_in       = data_q;
  assign fir_coef_enable   = coef_en_q;
  assign fir_sample_enable = smp_en_q;
  assign res_valid         = !fifo_empty;
  assign busy              = (state_q != StIdle);
  assign err               = err_q;

  fir_res_fifo #(
    .Width (OUT_W),
    .Depth (RES_DEPTH)
  ) u_res_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (fifo_push),
    .push_data_i (fir_data_out),
    .pop_i       (fifo_pop),
    .head_o      (res_data),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Next-state: handshakes, credit tracking and controller transitions; faults override all.
  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    out_cnt_d = out_cnt_q;
    data_d    = data_q;
    coef_en_d = 1'b0;
    smp_en_d  = 1'b0;
    err_d     = err_q;

    if (coef_xfer) begin
      data_d    = coef_data;
      coef_en_d = 1'b1;
      tap_cnt_d = tap_cnt_q + TapW'(1);
    end
    if (smp_xfer) begin
      data_d   = smp_data;
      smp_en_d = 1'b1;
    end

    case ({smp_xfer, ret_ok})
      2'b10:   out_cnt_d = out_cnt_q + CntW'(1);
      2'b01:   out_cnt_d = out_cnt_q - CntW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoad;
          tap_cnt_d = '0;
        end
      end
      StLoad: begin
        if (coef_xfer && (tap_cnt_q == TapW'(NUM_TAPS - 1))) state_d = StGap;
      end
      StGap: state_d = StStream;
      StStream: begin
        if (stop) begin
          state_d = StDrain;
        end else if (start && (out_cnt_q == '0)) begin
          state_d   = StLoad;
          tap_cnt_d = '0;
        end
      end
      StDrain: begin
        if ((out_cnt_q == '0) && fifo_empty) state_d = StIdle;
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase

    if (fault_hit) begin
      state_d = StFault;
      err_d   = 1'b1;
    end
  end

  // Controller registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      tap_cnt_q <= '0;
      out_cnt_q <= '0;
      data_q    <= '0;
      coef_en_q <= 1'b0;
      smp_en_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      out_cnt_q <= out_cnt_d;
      data_q    <= data_d;
      coef_en_q <= coef_en_d;
      smp_en_q  <= smp_en_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_fir_driver.sv
// Self-checking bench for fir_driver with a 2-cycle-latency filter model and a result scoreboard.
module tb_fir_driver;

  localparam int NT = 5;
  localparam int DW = 8;
  localparam int OW = 16;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0, stop = 1'b0;
  logic [DW-1:0] coef_data = '0, smp_data = '0;
  logic          coef_valid = 1'b0, smp_valid = 1'b0;
  logic [OW-1:0] fir_data_out = '0;
  logic          fir_out_enable = 1'b0, fir_error = 1'b0, res_ready = 1'b0;
  logic          coef_ready, smp_ready, fir_coef_enable, fir_sample_enable;
  logic          res_valid, busy, err;
  logic [DW-1:0] fir_data_in;
  logic [OW-1:0] res_data;

  int vectors = 0;
  int miscompares = 0;

  // Filter model pipeline, scoreboard and high-level counts.
  logic          pv0 = 1'b0, pv1 = 1'b0;
  logic [DW-1:0] pd0 = '0, pd1 = '0;
  int            fseq = 0, hseq = 0, landed = 0;
  logic [OW-1:0] exp_q [$];
  logic [7:0]    coefs [NT];
  int            gaps [NT];

  fir_driver #(
    .NUM_TAPS  (NT),
    .DATA_W    (DW),
    .OUT_W     (OW),
    .RES_DEPTH (RD)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .stop              (stop),
    .coef_data         (coef_data),
    .coef_valid        (coef_valid),
    .coef_ready        (coef_ready),
    .smp_data          (smp_data),
    .smp_valid         (smp_valid),
    .smp_ready         (smp_ready),
    .fir_data_in       (fir_data_in),
    .fir_coef_enable   (fir_coef_enable),
    .fir_sample_enable (fir_sample_enable),
    .fir_data_out      (fir_data_out),
    .fir_out_enable    (fir_out_enable),
    .fir_error         (fir_error),
    .res_data          (res_data),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .busy              (busy),
    .err               (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance to the next negedge and step the filter model (sample seen -> result 2 cycles on).
  task automatic cyc();
    @(negedge clk);
    if (fir_out_enable) landed++;
    fir_out_enable = pv1;
    fir_data_out   = {8'(fseq), pd1};
    if (pv1) fseq++;
    pv1 = pv0;
    pd1 = pd0;
    pv0 = fir_sample_enable;
    pd0 = fir_data_in;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 0; stop = 0; coef_valid = 0; smp_valid = 0; res_ready = 0; fir_error = 0;
    fir_out_enable = 0; pv0 = 0; pv1 = 0; fseq = 0; hseq = 0; landed = 0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Coefficient load from IDLE with gaps[i] idle cycles before coef i; ends in STREAM.
  task automatic run_load();
    int pulses;
    logic v;
    logic [7:0] exp_d;
    pulses = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < NT; i++) begin
      for (int g = 0; g <= gaps[i]; g++) begin
        v = (g == gaps[i]);
        coef_valid = v;
        coef_data  = v ? coefs[i] : 8'($urandom);
        #1;
        vectors++;
        if (coef_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL load_ready tap%0d got %b want 1", i, coef_ready);
        end
        cyc();
        vectors++;
        if (fir_coef_enable !== v) begin
          miscompares++;
          $display("FAIL load_enable tap%0d got %b want %b", i, fir_coef_enable, v);
        end
        if (fir_coef_enable) pulses++;
        if (v || i > 0) begin
          exp_d = v ? coefs[i] : coefs[i-1];
          vectors++;
          if (fir_data_in !== exp_d) begin
            miscompares++;
            $display("FAIL load_data tap%0d got %0d want %0d", i, fir_data_in, exp_d);
          end
        end
      end
    end
    coef_valid = 1'b0;
    #1;
    vectors++;
    if (coef_ready !== 1'b0 || smp_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_ready got cr=%b sr=%b busy=%b want 0 0 1", coef_ready, smp_ready, busy);
    end
    cyc();
    vectors++;
    if (fir_coef_enable !== 1'b0 || fir_sample_enable !== 1'b0 || smp_ready !== 1'b1 ||
        fir_data_in !== coefs[NT-1]) begin
      miscompares++;
      $display("FAIL gap_cycle got ce=%b se=%b sr=%b d=%0d want 0 0 1 %0d", fir_coef_enable,
               fir_sample_enable, smp_ready, fir_data_in, coefs[NT-1]);
    end
    vectors++;
    if (pulses !== NT) begin
      miscompares++;
      $display("FAIL load_pulses got %0d want %0d", pulses, NT);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    vectors++;
    if ({coef_ready, smp_ready, fir_coef_enable, fir_sample_enable, res_valid, busy, err}
        !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 0000000", {coef_ready, smp_ready, fir_coef_enable,
               fir_sample_enable, res_valid, busy, err});
    end
    vectors++;
    if (fir_data_in !== '0 || res_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data got %0d/%0d want 0/0", fir_data_in, res_data);
    end
    @(negedge clk);
    reset = 1'b0;
    // Idle ignores everything but start.
    coef_valid = 1'b1; smp_valid = 1'b1; stop = 1'b1;
    cyc(); cyc();
    vectors++;
    if ({coef_ready, smp_ready, fir_coef_enable, fir_sample_enable, busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL idle_ignore got %b want 00000", {coef_ready, smp_ready, fir_coef_enable,
               fir_sample_enable, busy});
    end
    coef_valid = 1'b0; smp_valid = 1'b0; stop = 1'b0;
  endtask

  task automatic test_load_b2b();
    do_reset();
    for (int i = 0; i < NT; i++) begin
      coefs[i] = 8'(4 + i);
      gaps[i]  = 0;
    end
    run_load();
  endtask

  task automatic test_load_gapped();
    do_reset();
    for (int i = 0; i < NT; i++) begin
      coefs[i] = 8'(4 + i);
      gaps[i]  = (i == 1 || i == 2) ? 1 : 0;
    end
    run_load();
  endtask

  // Four unit samples with results held back: credit limit then in-order release.
  task automatic test_stream_backpressure();
    int issued;
    logic exp_r;
    do_reset();
    for (int i = 0; i < NT; i++) begin
      coefs[i] = 8'($urandom);
      gaps[i]  = 0;
    end
    run_load();
    issued = 0;
    res_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      smp_valid = 1'b1;
      smp_data  = 8'd1;
      #1;
      exp_r = (issued < RD);
      vectors++;
      if (smp_ready !== exp_r) begin
        miscompares++;
        $display("FAIL bp_ready cyc%0d got %b want %b", k, smp_ready, exp_r);
      end
      if (smp_ready) begin
        issued++;
        exp_q.push_back({8'(hseq), 8'd1});
        hseq++;
      end
      cyc();
    end
    smp_valid = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < RD; k++) begin
      #1;
      vectors++;
      if (res_valid !== 1'b1 || exp_q.size() == 0 || res_data !== exp_q[0]) begin
        miscompares++;
        $display("FAIL bp_result%0d got v=%b d=%h want v=1 d=%h", k, res_valid, res_data,
                 (exp_q.size() > 0) ? exp_q[0] : 16'hxxxx);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      cyc();
    end
    res_ready = 1'b0;
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_empty got %b want 0", res_valid);
    end
  endtask

  // Continues in STREAM from the previous test with nothing outstanding.
  task automatic test_stop_drain();
    int popped;
    bit done;
    res_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      smp_valid = 1'b1;
      smp_data  = 8'($urandom);
      #1;
      if (smp_ready) begin
        exp_q.push_back({8'(hseq), smp_data});
        hseq++;
      end
      cyc();
    end
    stop = 1'b1;
    smp_valid = 1'b1;
    #1;
    vectors++;
    if (smp_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_ready got %b want 0", smp_ready);
    end
    cyc();
    stop = 1'b0;
    vectors++;
    if (fir_sample_enable !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stop_issue got se=%b busy=%b want 0 1", fir_sample_enable, busy);
    end
    res_ready = 1'b1;
    popped = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      vectors++;
      if (smp_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL drain_ready got %b want 0", smp_ready);
      end
      if (res_valid) begin
        vectors++;
        if (exp_q.size() == 0 || res_data !== exp_q[0]) begin
          miscompares++;
          $display("FAIL drain_data got %h want %h", res_data,
                   (exp_q.size() > 0) ? exp_q[0] : 16'hxxxx);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        popped++;
      end
      cyc();
      if (busy === 1'b0) done = 1'b1;
    end
    smp_valid = 1'b0;
    res_ready = 1'b0;
    vectors++;
    if (!done || popped !== 2 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_idle got done=%b popped=%0d busy=%b want 1 2 0", done, popped, busy);
    end
  endtask

  task automatic test_fault();
    do_reset();
    for (int i = 0; i < NT; i++) begin
      coefs[i] = 8'($urandom);
      gaps[i]  = 0;
    end
    run_load();
    smp_valid = 1'b1;
    smp_data  = 8'($urandom);
    #1;
    if (smp_ready) begin
      exp_q.push_back({8'(hseq), smp_data});
      hseq++;
    end
    cyc();
    smp_valid = 1'b0;
    repeat (4) cyc();
    fir_error = 1'b1;
    smp_valid = 1'b1;
    cyc();
    fir_error = 1'b0;
    #1;
    vectors++;
    if ({fir_coef_enable, fir_sample_enable, coef_ready, smp_ready} !== 4'b0 ||
        err !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL fault_entry got en=%b err=%b busy=%b want 0000 1 1", {fir_coef_enable,
               fir_sample_enable, coef_ready, smp_ready}, err, busy);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    smp_valid = 1'b0;
    res_ready = 1'b1;
    #1;
    vectors++;
    if (fir_sample_enable !== 1'b0 || coef_ready !== 1'b0 || res_valid !== 1'b1 ||
        exp_q.size() == 0 || res_data !== exp_q[0]) begin
      miscompares++;
      $display("FAIL fault_hold got se=%b cr=%b v=%b d=%h want 0 0 1 %h", fir_sample_enable,
               coef_ready, res_valid, res_data, (exp_q.size() > 0) ? exp_q[0] : 16'hxxxx);
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    cyc();
    res_ready = 1'b0;
    vectors++;
    if (res_valid !== 1'b0 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL fault_drained got v=%b err=%b want 0 1", res_valid, err);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_reset got err=%b busy=%b want 0 0", err, busy);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    for (int i = 0; i < NT; i++) begin
      coefs[i] = 8'($urandom_range(1, 255));
      gaps[i]  = 0;
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      coef_valid = 1'b1;
      coef_data  = coefs[i];
      cyc();
    end
    coef_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({coef_ready, fir_coef_enable, fir_sample_enable, busy, err, res_valid} !== 6'b0 ||
        fir_data_in !== '0) begin
      miscompares++;
      $display("FAIL midload_reset got %b d=%0d want 000000 d=0", {coef_ready, fir_coef_enable,
               fir_sample_enable, busy, err, res_valid}, fir_data_in);
    end
    do_reset();
    run_load();
  endtask

  // Random sample/result traffic against credit and scoreboard expectations, then drain.
  task automatic test_random_stream();
    int issued, popped;
    logic exp_r, exp_v;
    bit done;
    do_reset();
    for (int i = 0; i < NT; i++) begin
      coefs[i] = 8'($urandom);
      gaps[i]  = $urandom_range(0, 2);
    end
    run_load();
    issued = 0;
    popped = 0;
    for (int k = 0; k < 80; k++) begin
      smp_valid = ($urandom_range(0, 3) != 0);
      smp_data  = 8'($urandom);
      res_ready = 1'($urandom_range(0, 1));
      #1;
      exp_r = ((issued - popped) < RD);
      exp_v = (landed > popped);
      vectors++;
      if (smp_ready !== exp_r || res_valid !== exp_v) begin
        miscompares++;
        $display("FAIL rnd_flags cyc%0d got sr=%b rv=%b want %b %b", k, smp_ready, res_valid,
                 exp_r, exp_v);
      end
      if (res_valid && exp_q.size() > 0) begin
        vectors++;
        if (res_data !== exp_q[0]) begin
          miscompares++;
          $display("FAIL rnd_data cyc%0d got %h want %h", k, res_data, exp_q[0]);
        end
      end
      if (smp_valid && smp_ready) begin
        exp_q.push_back({8'(hseq), smp_data});
        hseq++;
        issued++;
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        popped++;
      end
      cyc();
    end
    stop = 1'b1;
    smp_valid = 1'b0;
    res_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      #1;
      if (res_valid) begin
        vectors++;
        if (exp_q.size() == 0 || res_data !== exp_q[0]) begin
          miscompares++;
          $display("FAIL rnd_drain got %h want %h", res_data,
                   (exp_q.size() > 0) ? exp_q[0] : 16'hxxxx);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      cyc();
      if (busy === 1'b0) done = 1'b1;
    end
    stop = 1'b0;
    res_ready = 1'b0;
    vectors++;
    if (!done || exp_q.size() != 0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL rnd_end got done=%b left=%0d err=%b want 1 0 0", done, exp_q.size(), err);
    end
  endtask

  initial begin
    test_reset();
    test_load_b2b();
    test_load_gapped();
    test_stream_backpressure();
    test_stop_drain();
    test_fault();
    test_reset_mid_load();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
